// File: rtl/fw_ip2_cfg_readback.sv
// Configuration-chain readback: drives fw_config_clk, deserialises fw_config_out LSB-first
// into a word buffer, and serves buffer words and status to SW through registered read ports.
module fw_ip2_cfg_readback #(
    parameter int CHAIN_LEN = 256,
    parameter int CLK_DIV   = 4
) (
    input  logic        fw_clk,
    input  logic        fw_rst_n,
    input  logic        fw_dev_id_enable,
    input  logic        fw_op_code_w_reset,
    input  logic        fw_op_code_w_execute,
    input  logic        fw_op_code_r_data_array_0,
    input  logic        fw_op_code_r_status,
    input  logic [23:0] sw_write24_0,
    output logic [31:0] fw_read_data32,
    output logic [31:0] fw_read_status32,
    output logic        fw_config_clk,
    input  logic        fw_config_out
);

    localparam int          DEPTH      = CHAIN_LEN / 32;
    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] CHAIN_LEN_W = 16'(CHAIN_LEN);
    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0]  CLK_DIV_W  = 8'(CLK_DIV);
    localparam logic [31:0] DEPTH_W    = 32'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic          cfg_clk_q, cfg_clk_d;
    logic [15:0]   bits_q, bits_d;
    logic [15:0]   n_q, n_d;
    logic          done_q, done_d;
    logic          clamp_q, clamp_d;
    logic [31:0]   acc_q, acc_d;
    logic          sync1_q, sync2_q;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   rstat_q, rstat_d;
    logic [31:0]   buf_q [DEPTH];

    logic          srst_s, start_s, sample_s, busy_s, rd_ok_s;
    logic [15:0]   n_req_s;
    logic [7:0]    addr_s;
    logic [5:0]    m_s;
    logic [31:0]   acc_shift_s;
    logic          buf_we_s;
    logic [AW-1:0] buf_wa_s;
    logic [31:0]   buf_wd_s;
    logic          unused_s;

    assign srst_s   = fw_dev_id_enable & fw_op_code_w_reset;
    assign start_s  = fw_dev_id_enable & fw_op_code_w_execute & ~srst_s;
    assign n_req_s  = sw_write24_0[15:0];
    assign addr_s   = sw_write24_0[7:0];
    assign unused_s = ^sw_write24_0[23:16];
    assign busy_s   = (state_q == ST_LOW) || (state_q == ST_HIGH);

    // Capture sequencer: start handling, config clock phases and bit counting
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cfg_clk_d = cfg_clk_q;
        bits_d    = bits_q;
        n_d       = n_q;
        done_d    = done_q;
        clamp_d   = clamp_q;
        sample_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    state_d   = ST_LOW;
                    div_d     = 8'd0;
                    cfg_clk_d = 1'b0;
                    bits_d    = 16'd0;
                    done_d    = 1'b0;
                    if (n_req_s == 16'd0) begin
                        n_d     = CHAIN_LEN_W;
                        clamp_d = 1'b0;
                    end else if (n_req_s > CHAIN_LEN_W) begin
                        n_d     = CHAIN_LEN_W;
                        clamp_d = 1'b1;
                    end else begin
                        n_d     = n_req_s;
                        clamp_d = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d     = 8'd0;
                    state_d   = ST_HIGH;
                    cfg_clk_d = 1'b1;
                    sample_s  = 1'b1;
                    bits_d    = bits_q + 16'd1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d     = 8'd0;
                    cfg_clk_d = 1'b0;
                    if (bits_q < n_q) begin
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cfg_clk_d = 1'b0;
            end
        endcase
    end

    // Shift accumulator; a partial final word is right-aligned so its upper bits read as zero
    always_comb begin
        m_s         = {1'b0, bits_q[4:0]} + 6'd1;
        acc_shift_s = {sync2_q, acc_q[31:1]};
        buf_wa_s    = bits_q[AW+4:5];
        buf_wd_s    = acc_shift_s >> (6'd32 - m_s);
        if (sample_s) begin
            acc_d    = acc_shift_s;
            buf_we_s = (bits_q[4:0] == 5'd31) || ((bits_q + 16'd1) == n_q);
        end else begin
            acc_d    = acc_q;
            buf_we_s = 1'b0;
        end
    end

    // SW read ports: each strobe serves its own output independently
    always_comb begin
        rd_ok_s = ({24'd0, addr_s} < DEPTH_W);
        if (fw_dev_id_enable && fw_op_code_r_data_array_0 && rd_ok_s) begin
            rdata_d = buf_q[addr_s[AW-1:0]];
        end else begin
            rdata_d = 32'd0;
        end
        if (fw_dev_id_enable && fw_op_code_r_status) begin
            rstat_d = {bits_q, CLK_DIV_W, 5'd0, clamp_q, done_q, busy_s};
        end else begin
            rstat_d = 32'd0;
        end
    end

    // Control state, synchroniser and output registers
    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= 8'd0;
            cfg_clk_q <= 1'b0;
            bits_q    <= 16'd0;
            n_q       <= 16'd0;
            done_q    <= 1'b0;
            clamp_q   <= 1'b0;
            acc_q     <= 32'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rstat_q   <= 32'd0;
        end else if (srst_s) begin
            state_q   <= ST_IDLE;
            div_q     <= 8'd0;
            cfg_clk_q <= 1'b0;
            bits_q    <= 16'd0;
            n_q       <= 16'd0;
            done_q    <= 1'b0;
            clamp_q   <= 1'b0;
            acc_q     <= 32'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rstat_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cfg_clk_q <= cfg_clk_d;
            bits_q    <= bits_d;
            n_q       <= n_d;
            done_q    <= done_d;
            clamp_q   <= clamp_d;
            acc_q     <= acc_d;
            sync1_q   <= fw_config_out;
            sync2_q   <= sync1_q;
            rdata_q   <= rdata_d;
            rstat_q   <= rstat_d;
        end
    end

    // Capture buffer: cleared by either reset, written once per completed or final word
    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= 32'd0;
        end else if (srst_s) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= 32'd0;
        end else if (buf_we_s) begin
            buf_q[buf_wa_s] <= buf_wd_s;
        end
    end

    assign fw_config_clk    = cfg_clk_q;
    assign fw_read_data32   = rdata_q;
    assign fw_read_status32 = rstat_q;

endmodule
